// File: rtl/rv_divide_issue.sv
// rv_divide_issue
//
// Issue/writeback sequencer placed between decode and the iterative divider.
// Accepts one DIV/DIVU/REM/REMU at a time and resolves the RISC-V special
// cases (rd = x0, divide by zero, signed overflow) in a single cycle without
// the divider. Every other operation launches the divider. The result is held
// until writeback takes it. A flush (x_kill_i) drops whatever is in flight.
//
// Ports
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   x_kill_i                       pipeline flush
//   d_valid_i / d_ready_o          decode handshake
//   d_fun_i, d_rs1_i, d_rs2_i      funct3 and operands from decode
//   d_rd_i                         destination register
//   div_start_o / div_abort_o      one-cycle launch / cancel pulses
//   div_rs1_o, div_rs2_o           registered operands for the divider
//   div_fun_o                      registered funct3 for the divider
//   div_done_i, div_result_i       divider completion and value
//   w_valid_o / w_ready_i          writeback handshake
//   w_rd_o, w_result_o             destination and value for writeback

module rv_divide_issue (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        x_kill_i,
    input  logic        d_valid_i,
    output logic        d_ready_o,
    input  logic [2:0]  d_fun_i,
    input  logic [31:0] d_rs1_i,
    input  logic [31:0] d_rs2_i,
    input  logic [4:0]  d_rd_i,
    output logic        div_start_o,
    output logic        div_abort_o,
    output logic [31:0] div_rs1_o,
    output logic [31:0] div_rs2_o,
    output logic [2:0]  div_fun_o,
    input  logic        div_done_i,
    input  logic [31:0] div_result_i,
    output logic        w_valid_o,
    input  logic        w_ready_i,
    output logic [4:0]  w_rd_o,
    output logic [31:0] w_result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;
    logic [31:0] div_rs1_q, div_rs1_d;
    logic [31:0] div_rs2_q, div_rs2_d;
    logic [2:0]  div_fun_q, div_fun_d;
    logic [4:0]  w_rd_q, w_rd_d;
    logic [31:0] w_result_q, w_result_d;

    logic        accept;
    logic        take_new;
    logic        is_rd_zero;
    logic        is_div_zero;
    logic        is_overflow;
    logic [31:0] fast_result;

    // Ready while idle, or while a held result is leaving this very cycle,
    // so a new operation can slip in behind the draining one.
    assign d_ready_o = !x_kill_i &&
                       ((state_q == S_IDLE) || ((state_q == S_HOLD) && w_ready_i));
    assign accept    = d_valid_i && d_ready_o;

    // Special-case classification of the operation currently on the decode
    // port. funct3[0] set means unsigned, funct3[1] set means remainder.
    always_comb begin
        is_rd_zero  = (d_rd_i == 5'd0);
        is_div_zero = (d_rs2_i == 32'd0);
        is_overflow = !d_fun_i[0] && (d_rs1_i == 32'h8000_0000) &&
                      (d_rs2_i == 32'hFFFF_FFFF);
        fast_result = 32'd0;
        if (is_div_zero) begin
            fast_result = d_fun_i[1] ? d_rs1_i : 32'hFFFF_FFFF;
        end else if (is_overflow) begin
            fast_result = d_fun_i[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Next-state logic. A kill always wins over done/ready; a newly accepted
    // operation is classified identically whether it came from IDLE or HOLD.
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        abort_d    = 1'b0;
        div_rs1_d  = div_rs1_q;
        div_rs2_d  = div_rs2_q;
        div_fun_d  = div_fun_q;
        w_rd_d     = w_rd_q;
        w_result_d = w_result_q;
        take_new   = 1'b0;

        case (state_q)
            S_IDLE: begin
                take_new = accept;
            end
            S_RUN: begin
                if (x_kill_i) begin
                    state_d = S_IDLE;
                    abort_d = 1'b1;
                end else if (div_done_i) begin
                    state_d    = S_HOLD;
                    w_result_d = div_result_i;
                end
            end
            S_HOLD: begin
                if (x_kill_i) begin
                    state_d = S_IDLE;
                end else if (w_ready_i) begin
                    state_d  = S_IDLE;
                    take_new = accept;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (take_new) begin
            if (is_rd_zero) begin
                state_d = S_IDLE;
            end else if (is_div_zero || is_overflow) begin
                state_d    = S_HOLD;
                w_rd_d     = d_rd_i;
                w_result_d = fast_result;
            end else begin
                state_d   = S_RUN;
                start_d   = 1'b1;
                div_rs1_d = d_rs1_i;
                div_rs2_d = d_rs2_i;
                div_fun_d = d_fun_i;
                w_rd_d    = d_rd_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            abort_q    <= 1'b0;
            div_rs1_q  <= 32'd0;
            div_rs2_q  <= 32'd0;
            div_fun_q  <= 3'd0;
            w_rd_q     <= 5'd0;
            w_result_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            abort_q    <= abort_d;
            div_rs1_q  <= div_rs1_d;
            div_rs2_q  <= div_rs2_d;
            div_fun_q  <= div_fun_d;
            w_rd_q     <= w_rd_d;
            w_result_q <= w_result_d;
        end
    end

    assign div_start_o = start_q;
    assign div_abort_o = abort_q;
    assign div_rs1_o   = div_rs1_q;
    assign div_rs2_o   = div_rs2_q;
    assign div_fun_o   = div_fun_q;
    assign w_valid_o   = (state_q == S_HOLD);
    assign w_rd_o      = w_rd_q;
    assign w_result_o  = w_result_q;

endmodule

// File: tb/tb_rv_divide_issue.sv
// tb_rv_divide_issue
//
// Self-checking bench for rv_divide_issue. A table of operations covers the
// normal, divide-by-zero, overflow and rd = x0 paths; hand-written sequences
// cover backpressure, kills and asynchronous reset. Expected writebacks are
// queued when an operation is driven and popped when a writeback transfer is
// observed.

module tb_rv_divide_issue;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        x_kill_i;
    logic        d_valid_i;
    logic        d_ready_o;
    logic [2:0]  d_fun_i;
    logic [31:0] d_rs1_i;
    logic [31:0] d_rs2_i;
    logic [4:0]  d_rd_i;
    logic        div_start_o;
    logic        div_abort_o;
    logic [31:0] div_rs1_o;
    logic [31:0] div_rs2_o;
    logic [2:0]  div_fun_o;
    logic        div_done_i;
    logic [31:0] div_result_i;
    logic        w_valid_o;
    logic        w_ready_i;
    logic [4:0]  w_rd_o;
    logic [31:0] w_result_o;

    localparam logic [2:0] F_DIV  = 3'b100;
    localparam logic [2:0] F_DIVU = 3'b101;
    localparam logic [2:0] F_REM  = 3'b110;
    localparam logic [2:0] F_REMU = 3'b111;

    typedef struct {
        logic [2:0]  fun;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        bit          launch;
        bit          valid;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] res;
    } wb_t;

    vec_t vecs[10];
    wb_t  sb[$];
    int   n_checks    = 0;
    int   n_fails     = 0;
    int   start_count = 0;
    int   exp_starts  = 0;

    rv_divide_issue dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .x_kill_i     (x_kill_i),
        .d_valid_i    (d_valid_i),
        .d_ready_o    (d_ready_o),
        .d_fun_i      (d_fun_i),
        .d_rs1_i      (d_rs1_i),
        .d_rs2_i      (d_rs2_i),
        .d_rd_i       (d_rd_i),
        .div_start_o  (div_start_o),
        .div_abort_o  (div_abort_o),
        .div_rs1_o    (div_rs1_o),
        .div_rs2_o    (div_rs2_o),
        .div_fun_o    (div_fun_o),
        .div_done_i   (div_done_i),
        .div_result_i (div_result_i),
        .w_valid_o    (w_valid_o),
        .w_ready_i    (w_ready_i),
        .w_rd_o       (w_rd_o),
        .w_result_o   (w_result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_output(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference divider behaviour for operations that reach the divider.
    function automatic logic [31:0] ref_div(input logic [2:0] f,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        case (f)
            F_DIV:   return $signed(a) / $signed(b);
            F_DIVU:  return a / b;
            F_REM:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    // Writeback monitor: a transfer happens when valid and ready meet without
    // a kill in the same cycle.
    always @(negedge clk_i) begin
        if (rst_n_i && w_valid_o && w_ready_i && !x_kill_i) begin
            if (sb.size() == 0) begin
                check_output("unexpected_wb", 128'(w_rd_o), 128'(0));
                check_output("unexpected_wb_valid", 128'(1), 128'(0));
            end else begin
                wb_t e;
                e = sb.pop_front();
                check_output("wb_rd", 128'(w_rd_o), 128'(e.rd));
                check_output("wb_result", 128'(w_result_o), 128'(e.res));
            end
        end
        if (rst_n_i && div_start_o) start_count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_stimulus(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b, input logic [4:0] rd);
        d_valid_i = 1'b1;
        d_fun_i   = f;
        d_rs1_i   = a;
        d_rs2_i   = b;
        d_rd_i    = rd;
    endtask

    task automatic release_op();
        d_valid_i = 1'b0;
        d_fun_i   = 3'd0;
        d_rs1_i   = 32'd0;
        d_rs2_i   = 32'd0;
        d_rd_i    = 5'd0;
    endtask

    task automatic push_wb(input logic [4:0] rd, input logic [31:0] res);
        wb_t e;
        e.rd  = rd;
        e.res = res;
        sb.push_back(e);
    endtask

    task automatic finish_div(input int lat, input logic [31:0] res);
        repeat (lat) tick();
        div_done_i   = 1'b1;
        div_result_i = res;
        tick();
        div_done_i   = 1'b0;
        div_result_i = 32'd0;
    endtask

    task automatic drain();
        w_ready_i = 1'b1;
        tick();
        w_ready_i = 1'b0;
    endtask

    task automatic run_vector(input vec_t v);
        apply_stimulus(v.fun, v.rs1, v.rs2, v.rd);
        if (v.valid) push_wb(v.rd, v.exp);
        if (v.launch) exp_starts++;
        @(negedge clk_i);
        check_output("vec_ready", 128'(d_ready_o), 128'(1));
        tick();
        release_op();
        check_output("vec_start", 128'(div_start_o), 128'(v.launch));
        if (v.launch) begin
            check_output("vec_div_ops", {div_fun_o, div_rs1_o, div_rs2_o},
                         {v.fun, v.rs1, v.rs2});
            finish_div(33, ref_div(v.fun, v.rs1, v.rs2));
            check_output("vec_valid_after_done", 128'(w_valid_o), 128'(1));
        end else if (v.valid) begin
            check_output("vec_fast_valid", 128'(w_valid_o), 128'(1));
        end else begin
            check_output("vec_rd0_valid", 128'(w_valid_o), 128'(0));
            check_output("vec_rd0_ready", 128'(d_ready_o), 128'(1));
        end
        if (v.valid) begin
            drain();
            check_output("vec_valid_cleared", 128'(w_valid_o), 128'(0));
        end
        check_output("vec_sb_empty", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        bit ok;

        vecs[0] = '{F_DIVU, 32'd100,          32'd7,           5'd5,  1, 1, 32'd14};
        vecs[1] = '{F_REM,  32'hFFFF_FF9C,    32'd7,           5'd6,  1, 1, 32'hFFFF_FFFE};
        vecs[2] = '{F_DIV,  32'd42,           32'd0,           5'd7,  0, 1, 32'hFFFF_FFFF};
        vecs[3] = '{F_REMU, 32'd42,           32'd0,           5'd8,  0, 1, 32'd42};
        vecs[4] = '{F_DIV,  32'h8000_0000,    32'hFFFF_FFFF,   5'd9,  0, 1, 32'h8000_0000};
        vecs[5] = '{F_REM,  32'h8000_0000,    32'hFFFF_FFFF,   5'd10, 0, 1, 32'd0};
        vecs[6] = '{F_DIVU, 32'h8000_0000,    32'hFFFF_FFFF,   5'd11, 1, 1, 32'd0};
        vecs[7] = '{F_DIV,  32'd42,           32'd3,           5'd0,  0, 0, 32'd0};
        vecs[8] = '{F_DIV,  32'd42,           32'd0,           5'd0,  0, 0, 32'd0};
        vecs[9] = '{F_DIV,  32'hFFFF_FF9C,    32'd7,           5'd12, 1, 1, 32'hFFFF_FFF2};

        rst_n_i      = 1'b0;
        x_kill_i     = 1'b0;
        w_ready_i    = 1'b0;
        div_done_i   = 1'b0;
        div_result_i = 32'd0;
        release_op();

        #12;
        check_output("reset_outputs",
                     {div_start_o, div_abort_o, w_valid_o, w_rd_o, w_result_o,
                      div_rs1_o, div_rs2_o, div_fun_o}, 128'd0);
        check_output("reset_ready", 128'(d_ready_o), 128'(1));
        rst_n_i = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) run_vector(vecs[i]);

        // Writeback backpressure followed by same-cycle drain and new issue.
        apply_stimulus(F_DIVU, 32'd100, 32'd7, 5'd5);
        push_wb(5'd5, 32'd14);
        exp_starts++;
        tick();
        release_op();
        check_output("bp_start", 128'(div_start_o), 128'(1));
        finish_div(33, 32'd14);
        ok = 1;
        for (int i = 0; i < 10; i++) begin
            if (!(w_valid_o === 1'b1 && w_rd_o === 5'd5 && w_result_o === 32'd14 &&
                  d_ready_o === 1'b0)) ok = 0;
            tick();
        end
        check_output("bp_stable", 128'(ok), 128'(1));
        w_ready_i = 1'b1;
        apply_stimulus(F_DIV, 32'd1000, 32'd10, 5'd13);
        push_wb(5'd13, 32'd100);
        exp_starts++;
        @(negedge clk_i);
        check_output("bp_ready_on_drain", 128'(d_ready_o), 128'(1));
        tick();
        release_op();
        w_ready_i = 1'b0;
        check_output("bp_new_start", 128'(div_start_o), 128'(1));
        check_output("bp_new_run", 128'(w_valid_o), 128'(0));
        finish_div(5, 32'd100);
        check_output("bp_new_valid", 128'(w_valid_o), 128'(1));
        drain();
        check_output("bp_sb_empty", 128'(sb.size()), 128'(0));

        // Kill five cycles into RUN, then a late done.
        apply_stimulus(F_DIVU, 32'd100, 32'd7, 5'd14);
        exp_starts++;
        tick();
        release_op();
        check_output("krun_start", 128'(div_start_o), 128'(1));
        repeat (4) tick();
        x_kill_i = 1'b1;
        tick();
        x_kill_i = 1'b0;
        check_output("krun_abort", 128'(div_abort_o), 128'(1));
        tick();
        check_output("krun_abort_once", 128'(div_abort_o), 128'(0));
        check_output("krun_idle_ready", 128'(d_ready_o), 128'(1));
        finish_div(0, 32'd14);
        check_output("krun_late_done", 128'(w_valid_o), 128'(0));

        // Kill in HOLD while writeback is ready: nothing transfers.
        apply_stimulus(F_DIV, 32'd42, 32'd0, 5'd15);
        tick();
        release_op();
        check_output("khold_valid", 128'(w_valid_o), 128'(1));
        x_kill_i  = 1'b1;
        w_ready_i = 1'b1;
        tick();
        x_kill_i  = 1'b0;
        w_ready_i = 1'b0;
        check_output("khold_dropped", 128'(w_valid_o), 128'(0));

        // Kill together with done: result discarded.
        apply_stimulus(F_DIVU, 32'd100, 32'd7, 5'd16);
        exp_starts++;
        tick();
        release_op();
        check_output("kdone_start", 128'(div_start_o), 128'(1));
        repeat (3) tick();
        div_done_i   = 1'b1;
        div_result_i = 32'd14;
        x_kill_i     = 1'b1;
        tick();
        div_done_i   = 1'b0;
        div_result_i = 32'd0;
        x_kill_i     = 1'b0;
        check_output("kdone_no_valid", 128'(w_valid_o), 128'(0));
        check_output("kdone_abort", 128'(div_abort_o), 128'(1));
        tick();
        check_output("kdone_still_idle", 128'(w_valid_o), 128'(0));

        // Asynchronous reset in the middle of RUN.
        apply_stimulus(F_DIV, 32'd1000, 32'd10, 5'd17);
        exp_starts++;
        tick();
        release_op();
        check_output("rst_start", 128'(div_start_o), 128'(1));
        repeat (3) tick();
        check_output("rst_ops_loaded", {div_rs1_o, div_rs2_o}, {32'd1000, 32'd10});
        #2;
        rst_n_i = 1'b0;
        #1;
        check_output("rst_async_clear",
                     {div_start_o, div_abort_o, w_valid_o, w_rd_o, w_result_o,
                      div_rs1_o, div_rs2_o, div_fun_o}, 128'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        check_output("rst_ready", 128'(d_ready_o), 128'(1));
        check_output("rst_no_valid", 128'(w_valid_o), 128'(0));

        check_output("start_count", 128'(start_count), 128'(exp_starts));
        check_output("final_sb_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
